// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a single-port word memory: byte/half/word accesses at any byte
// address, word-crossing accesses split into two memory cycles, aligned and extended load data.
module lsu_mem_initiator #(
  parameter logic MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rready,
  output logic        mem_wready,
  output logic [31:2] mem_raddr,
  output logic [31:2] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, A0, D0, D1, W1} state_t;
  state_t state, state_nxt;

  logic        we_q, signed_q;
  logic [1:0]  off_q, size_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q, lo_q;
  logic [29:0] raddr_hold, waddr_hold;
  logic [31:0] wdata_hold;
  logic        accept, req_err, span, hi_sel, done;
  logic [7:0]  mask8;
  logic [63:0] d64, rd_pair;
  logic [29:0] word_sel;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;

  function automatic logic spans(input logic [1:0] off, input logic [1:0] size);
    return ({2'b00, off} + (4'd1 << size)) > 4'd4;
  endfunction

  function automatic logic [31:0] bytemask(input logic [1:0] size);
    case (size)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] strobe4(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Align the two-word read window to byte 0, then zero- or sign-extend to 32 bits.
  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [63:0]        v;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    v = pair >> {off, 3'b000};
    b = v[7:0];
    h = v[15:0];
    case (size)
      2'd0: begin
        sx = b;
        return sgn ? sx : {24'd0, v[7:0]};
      end
      2'd1: begin
        sx = h;
        return sgn ? sx : {16'd0, v[15:0]};
      end
      default: return v[31:0];
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = (req_size == 2'd3) || (!MISALIGNED && spans(req_addr[1:0], req_size));
  assign span      = spans(off_q, size_q);

  assign mask8     = {4'b0000, strobe4(size_q)} << off_q;
  assign d64       = {32'd0, wdata_q & bytemask(size_q)} << {off_q, 3'b000};
  assign word_sel  = hi_sel ? word_q + 30'd1 : word_q;
  assign lane_data = hi_sel ? d64[63:32] : d64[31:0];
  assign lane_strb = hi_sel ? mask8[7:4] : mask8[3:0];
  assign rd_pair   = (state == D1) ? {mem_rdata, lo_q} : {32'd0, mem_rdata};

  // Memory address/data buses keep their last driven value between accesses.
  assign mem_raddr = mem_rready ? word_sel : raddr_hold;
  assign mem_waddr = mem_wready ? word_sel : waddr_hold;
  assign mem_wdata = mem_wready ? lane_data : wdata_hold;
  assign mem_wstrb = mem_wready ? lane_strb : 4'd0;

  always_comb begin
    state_nxt  = state;
    mem_rready = 1'b0;
    mem_wready = 1'b0;
    hi_sel     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (accept && !req_err) state_nxt = A0;
      A0: begin
        if (we_q) begin
          mem_wready = 1'b1;
          if (span) begin
            state_nxt = W1;
          end else begin
            state_nxt = IDLE;
            done      = 1'b1;
          end
        end else begin
          mem_rready = 1'b1;
          state_nxt  = D0;
        end
      end
      D0: begin
        if (span) begin
          mem_rready = 1'b1;
          hi_sel     = 1'b1;
          state_nxt  = D1;
        end else begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      D1: begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      W1: begin
        mem_wready = 1'b1;
        hi_sel     = 1'b1;
        state_nxt  = IDLE;
        done       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      raddr_hold <= 30'd0;
      waddr_hold <= 30'd0;
      wdata_hold <= 32'd0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      if (mem_rready) raddr_hold <= word_sel;
      if (mem_wready) begin
        waddr_hold <= word_sel;
        wdata_hold <= lane_data;
      end
      if (accept && req_err) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        resp_rdata <= 32'd0;
      end else if (done) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= we_q ? 32'd0 : extract(rd_pair, off_q, size_q, signed_q);
      end
    end
  end

  // Request capture and low-word holding register carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      off_q    <= req_addr[1:0];
      word_q   <= req_addr[31:2];
      size_q   <= req_size;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
    end
    if (state == D0) lo_q <= mem_rdata;
  end

endmodule
